flag_update_unit: RTL and testbench

- Produces and holds the 3-bit condition-flag register {N, Z, V} that the branch evaluator consumes.
- Sits at the EX stage output. Samples the ALU result, ALU overflow and opcode of each valid instruction, and updates only the flags that opcode is architecturally allowed to write.
- Tracks in-flight flag writers so decode can stall a conditional branch until its flags are final.

---
 rtl/flag_update_unit.sv | 148 ++++++++++++++
 tb/tb_flag_update_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/flag_update_unit.sv
// Purpose: holds the {N,Z,V} condition flags written by EX-stage instructions and tracks in-flight flag writers.
// Latency: a committing flag writer in EX at cycle t is visible on flag_reg at t+1; flags_pending is registered.
// Backpressure: ex_stall freezes flag_reg and the EX retire event; the optional FLAG_BYPASS_EN macro adds flag_fwd.
module flag_update_unit #(
    parameter int DATA_W = 16,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_stall,
    input  logic              ex_flush,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovfl,
    input  logic              id_issue_flag_wr,
    output logic [2:0]        flag_reg,
    output logic              flags_updated,
    output logic              flags_pending
`ifdef FLAG_BYPASS_EN
    ,
    output logic [2:0]        flag_fwd
`endif
);

    // Opcode encodings that own flag-write permissions.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;

    // Mask bit positions match flag_reg: [2]=N, [1]=Z, [0]=V.
    localparam logic [2:0] MASK_NZV  = 3'b111;
    localparam logic [2:0] MASK_Z    = 3'b010;
    localparam logic [2:0] MASK_NONE = 3'b000;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    logic [2:0]        r_flag;
    logic              r_updated;
    logic [PEND_W-1:0] r_cnt;
    logic              r_pending;

    logic              w_commit;
    logic              w_leave_ex;
    logic [2:0]        w_mask;
    logic [2:0]        w_new_flags;
    logic [2:0]        w_flag_nxt;
    logic              w_inc;
    logic              w_dec;
    logic [PEND_W-1:0] w_cnt_nxt;

    // An instruction commits only if it is valid, moving, and not squashed;
    // it leaves EX whenever it is valid and moving, squashed or not.
    assign w_commit   = ex_valid & ~ex_stall & ~ex_flush;
    assign w_leave_ex = ex_valid & ~ex_stall;

    // Architectural flag-write permissions per opcode; everything else writes nothing.
    always_comb begin
        w_mask = MASK_NONE;
        case (alu_op)
            OP_ADD, OP_SUB:         w_mask = MASK_NZV;
            OP_XOR, OP_SLL,
            OP_SRA, OP_ROR:         w_mask = MASK_Z;
            default:                w_mask = MASK_NONE;
        endcase
    end

    // Candidate flag values derived from the ALU outputs.
    assign w_new_flags = {alu_result[DATA_W-1], (alu_result == '0), alu_ovfl};

    // Merge masked new flags with held flags on commit; otherwise hold.
    always_comb begin
        w_flag_nxt = r_flag;
        if (w_commit) begin
            w_flag_nxt = (w_mask & w_new_flags) | (~w_mask & r_flag);
        end
    end

    // Flag register and its update pulse; the pulse fires on any non-zero-mask commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag    <= 3'b000;
            r_updated <= 1'b0;
        end else begin
            r_flag    <= w_flag_nxt;
            r_updated <= w_commit & (|w_mask);
        end
    end

    assign w_inc = id_issue_flag_wr;

`ifdef FLAG_BYPASS_EN
    logic r_issue_d;

    // With forwarding, a writer stops being "pending" as soon as it enters EX,
    // which is the cycle after decode issued it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_d <= 1'b0;
        end else begin
            r_issue_d <= id_issue_flag_wr;
        end
    end

    assign w_dec    = r_issue_d;
    assign flag_fwd = w_flag_nxt;
`else
    // Without forwarding, a writer is pending until it leaves EX (flushed writers
    // also leave, so they retire the count without writing flags).
    assign w_dec = w_leave_ex & (|w_mask);
`endif

    // Saturating in-flight counter: simultaneous issue and retire cancel out,
    // increments stop at the maximum, decrements stop at zero.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_inc && !w_dec) begin
            if (r_cnt != PEND_MAX) begin
                w_cnt_nxt = r_cnt + PEND_ONE;
            end
        end else if (!w_inc && w_dec) begin
            if (r_cnt != PEND_ZERO) begin
                w_cnt_nxt = r_cnt - PEND_ONE;
            end
        end
    end

    // Counter and its non-zero indication are registered together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= PEND_ZERO;
            r_pending <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_pending <= (w_cnt_nxt != PEND_ZERO);
        end
    end

    assign flag_reg      = r_flag;
    assign flags_updated = r_updated;
    assign flags_pending = r_pending;

endmodule

// File: tb/tb_flag_update_unit.sv
// Directed bench for flag_update_unit: each step drives EX/ID inputs, queues the
// expected outputs, and compares them one clock later (or immediately for async reset).
module tb_flag_update_unit;

    localparam int DATA_W = 16;
    localparam int PEND_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_valid;
    logic              ex_stall;
    logic              ex_flush;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_ovfl;
    logic              id_issue_flag_wr;
    logic [2:0]        flag_reg;
    logic              flags_updated;
    logic              flags_pending;

    flag_update_unit #(.DATA_W(DATA_W), .PEND_W(PEND_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_flush         (ex_flush),
        .alu_op           (alu_op),
        .alu_result       (alu_result),
        .alu_ovfl         (alu_ovfl),
        .id_issue_flag_wr (id_issue_flag_wr),
        .flag_reg         (flag_reg),
        .flags_updated    (flags_updated),
        .flags_pending    (flags_pending)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, XOR = 4'b0010, RED = 4'b0011;
    localparam logic [3:0] SLL = 4'b0100, SRA = 4'b0101, ROR = 4'b0110, PADDSB = 4'b0111;
    localparam logic [3:0] OP_HI = 4'b1000;

    typedef struct {
        logic [2:0] flags;
        logic       upd;
        logic       pend;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Drive one cycle's inputs at the falling edge.
    task automatic apply(input logic v, input logic s, input logic f, input logic [3:0] op,
                         input logic [DATA_W-1:0] res, input logic ov, input logic iss);
        @(negedge clk);
        ex_valid         = v;
        ex_stall         = s;
        ex_flush         = f;
        alu_op           = op;
        alu_result       = res;
        alu_ovfl         = ov;
        id_issue_flag_wr = iss;
    endtask

    task automatic push_exp(input logic [2:0] fl, input logic u, input logic p, input string tag);
        exp_t e;
        e.flags = fl;
        e.upd   = u;
        e.pend  = p;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL sb_empty: got no expectation, required one");
            return;
        end
        e = sb.pop_front();
        n_vec++;
        assert (flag_reg === e.flags) else begin
            n_err++;
            $error("FAIL %s.flag_reg: got %b required %b", e.tag, flag_reg, e.flags);
        end
        n_vec++;
        assert (flags_updated === e.upd) else begin
            n_err++;
            $error("FAIL %s.flags_updated: got %b required %b", e.tag, flags_updated, e.upd);
        end
        n_vec++;
        assert (flags_pending === e.pend) else begin
            n_err++;
            $error("FAIL %s.flags_pending: got %b required %b", e.tag, flags_pending, e.pend);
        end
    endtask

    // One clocked step: drive, queue expectation, then compare just after the edge.
    task automatic step(input logic v, input logic s, input logic f, input logic [3:0] op,
                        input logic [DATA_W-1:0] res, input logic ov, input logic iss,
                        input logic [2:0] fl, input logic u, input logic p, input string tag);
        apply(v, s, f, op, res, ov, iss);
        push_exp(fl, u, p, tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic idle(input logic [2:0] fl, input logic p, input string tag);
        step(1'b0, 1'b0, 1'b0, OP_HI, 16'h0000, 1'b0, 1'b0, fl, 1'b0, p, tag);
    endtask

    initial begin
        rst = 1'b1;
        ex_valid = 1'b0; ex_stall = 1'b0; ex_flush = 1'b0;
        alu_op = 4'b0000; alu_result = '0; alu_ovfl = 1'b0; id_issue_flag_wr = 1'b0;
        #2;
        push_exp(3'b000, 1'b0, 1'b0, "reset");
        check_out();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // ADD with negative result and overflow: N and V set.
        step(1, 0, 0, ADD, 16'h8000, 1, 0, 3'b101, 1, 0, "add_nv");
        idle(3'b101, 0, "add_nv_pulse_end");

        // SUB to zero, then XOR non-zero clears only Z.
        step(1, 0, 0, SUB, 16'h0000, 0, 0, 3'b010, 1, 0, "sub_z");
        step(1, 0, 0, XOR, 16'h0001, 1, 0, 3'b000, 1, 0, "xor_clr_z");
        idle(3'b000, 0, "xor_idle");

        // Non-writing opcodes leave flags alone and do not pulse.
        step(1, 0, 0, ADD, 16'h8000, 1, 0, 3'b101, 1, 0, "add_again");
        step(1, 0, 0, PADDSB, 16'h0000, 0, 0, 3'b101, 0, 0, "paddsb_hold");
        step(1, 0, 0, RED, 16'h0000, 0, 0, 3'b101, 0, 0, "red_hold");
        step(1, 0, 0, OP_HI, 16'h0000, 0, 0, 3'b101, 0, 0, "op1xxx_hold");

        // Stall holds for three cycles, then the commit lands one cycle after release.
        step(1, 1, 0, ADD, 16'h0000, 0, 0, 3'b101, 0, 0, "stall1");
        step(1, 1, 0, ADD, 16'h0000, 0, 0, 3'b101, 0, 0, "stall2");
        step(1, 1, 0, ADD, 16'h0000, 0, 0, 3'b101, 0, 0, "stall3");
        step(1, 0, 0, ADD, 16'h0000, 0, 0, 3'b010, 1, 0, "stall_release");
        idle(3'b010, 0, "stall_idle");

        // Pending counter: four issues saturate at 3, then three retires drain it.
        step(0, 0, 0, OP_HI, 16'h0000, 0, 1, 3'b010, 0, 1, "issue1");
        step(0, 0, 0, OP_HI, 16'h0000, 0, 1, 3'b010, 0, 1, "issue2");
        step(0, 0, 0, OP_HI, 16'h0000, 0, 1, 3'b010, 0, 1, "issue3");
        step(0, 0, 0, OP_HI, 16'h0000, 0, 1, 3'b010, 0, 1, "issue4_sat");
        step(1, 0, 0, ADD, 16'h0001, 0, 0, 3'b000, 1, 1, "retire1");
        step(1, 0, 1, SUB, 16'h0000, 1, 0, 3'b000, 0, 1, "retire2_flushed");
        step(1, 1, 0, XOR, 16'h0000, 0, 0, 3'b000, 0, 1, "retire3_stalled");
        step(1, 0, 0, XOR, 16'h0000, 0, 0, 3'b010, 1, 0, "retire3");

        // Simultaneous issue and retire cancel; non-writers do not retire the count.
        step(1, 0, 0, ADD, 16'h8000, 0, 1, 3'b100, 1, 0, "inc_dec_at0");
        step(0, 0, 0, OP_HI, 16'h0000, 0, 1, 3'b100, 0, 1, "issue_one");
        step(1, 0, 0, PADDSB, 16'h0000, 0, 0, 3'b100, 0, 1, "nonwriter_no_dec");
        step(1, 0, 0, SLL, 16'h0005, 0, 1, 3'b100, 1, 1, "inc_dec_at1");
        step(1, 0, 0, SRA, 16'h0000, 0, 0, 3'b110, 1, 0, "sra_retire");
        step(1, 0, 0, ROR, 16'h8001, 1, 0, 3'b100, 1, 0, "ror_z_only");

        // Mid-cycle reset during a committing ADD with a writer pending.
        step(0, 0, 0, OP_HI, 16'h0000, 0, 1, 3'b100, 0, 1, "pre_reset_issue");
        apply(1, 0, 0, ADD, 16'h8000, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        push_exp(3'b000, 1'b0, 1'b0, "rst_immediate");
        check_out();
        @(posedge clk);
        #1;
        push_exp(3'b000, 1'b0, 1'b0, "rst_held_edge");
        check_out();
        @(negedge clk);
        rst = 1'b0;
        ex_valid = 1'b0;
        idle(3'b000, 0, "post_reset_idle");
        step(1, 0, 0, ADD, 16'h8000, 1, 0, 3'b101, 1, 0, "post_reset_add");
        idle(3'b101, 0, "post_reset_pulse_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
